seg_scan_display: RTL and testbench

- Parametrised successor of the board seven-segment driver.
- Time-multiplexes NUM_DIGITS active-low common-anode digits from one of five CPU statistic/data sources.
- Binary-to-BCD conversion is a multi-cycle sequential double-dabble, replacing the combinational converter instances. The block also adds a clock-enable refresh divider, leading-zero blanking, overflow indication and synchronous reset.
- Sits at top level beside the CPU core; feeds board SEG/AN pins.

---
 rtl/seg_disp_pkg.sv | 45 ++++
 rtl/bcd_seq_conv.sv | 86 ++++++++
 rtl/seg_scan_display.sv | 152 +++++++++++++++
 tb/tb_seg_scan_display.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared definitions for the scanned seven-segment display: source-select
// encodings, glyph constants, the hex glyph decoder and converter states.
package seg_disp_pkg;

    localparam logic [2:0] OP_CPU    = 3'b000;
    localparam logic [2:0] OP_TOTAL  = 3'b001;
    localparam logic [2:0] OP_UNCOND = 3'b011;
    localparam logic [2:0] OP_COND   = 3'b111;
    localparam logic [2:0] OP_RAM    = 3'b010;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Active-low segment pattern for one hex nibble; bit7 (dp) stays off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h98;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hA7;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            4'hF: g = 8'h8E;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Free-running sequential double-dabble: latches bin_in, shifts it through a
// BCD register one bit per cycle and pulses done for one cycle with the
// result. A bit falling off the top BCD digit flags overflow.
module bcd_seq_conv
    import seg_disp_pkg::*;
#(
    parameter int BIN_W      = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BIN_W-1:0]        bin_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    ovf_out,
    output logic                    done
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t        state;
    conv_state_t        state_d;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   bin;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_acc;

    // Add 3 to every BCD digit that is 5 or more before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next-state logic: one latch cycle, BIN_W shift cycles, one done cycle.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch, shift-and-adjust, hold the result during DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd     <= '0;
            bin     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bin     <= bin_in;
                    bcd     <= '0;
                    cnt     <= CNT_W'(BIN_W);
                    ovf_acc <= 1'b0;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
                    ovf_acc    <= ovf_acc | bcd_adj[BCD_W-1];
                    cnt        <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = bcd;
    assign ovf_out = ovf_acc;
    assign done    = (state == DONE);

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment driver. A clock-enable divider steps the
// digit index; SEG/AN are registered on each tick so a digit's glyph never
// changes within its slot. Hex sources load directly, decimal sources go
// through the sequential BCD converter.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 100_000,
    parameter int BIN_W      = 32,
    localparam int DATA_W    = 4 * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            display_op,
    input  logic                  led_cpu_enable,
    input  logic                  blank_en,
    input  logic [DATA_W-1:0]     led_data_in,
    input  logic [BIN_W-1:0]      total_cycles,
    input  logic [BIN_W-1:0]      uncondi_branch_num,
    input  logic [BIN_W-1:0]      condi_branch_num,
    input  logic [DATA_W-1:0]     ram_display_data_out,
    output logic [7:0]            SEG,
    output logic [NUM_DIGITS-1:0] AN,
    output logic                  ovf
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [IDX_W-1:0]  digit_idx;
    logic [DATA_W-1:0] disp_reg;
    logic [BIN_W-1:0]  bin_sel;
    logic              is_dec;
    logic              is_valid;
    logic [DATA_W-1:0] conv_bcd;
    logic              conv_ovf;
    logic              conv_done;
    logic [IDX_W-1:0]  msd_idx;
    logic [3:0]        cur_nib;
    logic [7:0]        seg_d;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Refresh divider: one tick every CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // Digit index advances once per tick and wraps after the last digit.
    always_ff @(posedge clk) begin
        if (!rst_n)
            digit_idx <= '0;
        else if (tick)
            digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end

    // Source decode: pick the binary statistic and classify the mode.
    always_comb begin
        bin_sel  = '0;
        is_dec   = 1'b0;
        is_valid = 1'b1;
        case (display_op)
            OP_TOTAL:  begin bin_sel = total_cycles;       is_dec = 1'b1; end
            OP_UNCOND: begin bin_sel = uncondi_branch_num; is_dec = 1'b1; end
            OP_COND:   begin bin_sel = condi_branch_num;   is_dec = 1'b1; end
            OP_CPU, OP_RAM: ;
            default:   is_valid = 1'b0;
        endcase
    end

    bcd_seq_conv #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .bin_in  (bin_sel),
        .bcd_out (conv_bcd),
        .ovf_out (conv_ovf),
        .done    (conv_done)
    );

    // Display register: hex sources load directly, decimal results land on done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_reg <= '0;
            ovf      <= 1'b0;
        end else begin
            case (display_op)
                OP_CPU: begin
                    if (led_cpu_enable) disp_reg <= led_data_in;
                    ovf <= 1'b0;
                end
                OP_RAM: begin
                    disp_reg <= ram_display_data_out;
                    ovf      <= 1'b0;
                end
                OP_TOTAL, OP_UNCOND, OP_COND: begin
                    if (conv_done) begin
                        disp_reg <= conv_bcd;
                        ovf      <= conv_ovf;
                    end
                end
                default: begin
                    disp_reg <= '0;
                    ovf      <= 1'b0;
                end
            endcase
        end
    end

    // Highest non-zero digit position; 0 when the whole value is zero.
    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (disp_reg[4*i +: 4] != 4'h0) msd_idx = IDX_W'(i);
        end
    end

    assign cur_nib = disp_reg[{digit_idx, 2'b00} +: 4];

    // Glyph for the current digit: blank, dash, leading-zero blank or hex.
    always_comb begin
        seg_d = hex_glyph(cur_nib);
        if (!is_valid)
            seg_d = GLYPH_BLANK;
        else if (is_dec && ovf)
            seg_d = GLYPH_DASH;
        else if (is_dec && blank_en && (digit_idx > msd_idx))
            seg_d = GLYPH_BLANK;
    end

    // Registered pin drive, refreshed only on ticks so a slot never tears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            SEG <= GLYPH_BLANK;
            AN  <= '1;
        end else if (tick) begin
            SEG <= seg_d;
            AN  <= ~(NUM_DIGITS'(1) << digit_idx);
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a short refresh divider.
module tb_seg_scan_display;

  localparam int ND = 8;
  localparam int CD = 4;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    display_op;
  logic          led_cpu_enable;
  logic          blank_en;
  logic [31:0]   led_data_in;
  logic [BW-1:0] total_cycles;
  logic [BW-1:0] uncondi_branch_num;
  logic [BW-1:0] condi_branch_num;
  logic [31:0]   ram_display_data_out;
  logic [7:0]    seg;
  logic [ND-1:0] an;
  logic          ovf;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  seg_scan_display #(
    .NUM_DIGITS (ND),
    .CLK_DIV    (CD),
    .BIN_W      (BW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .display_op           (display_op),
    .led_cpu_enable       (led_cpu_enable),
    .blank_en             (blank_en),
    .led_data_in          (led_data_in),
    .total_cycles         (total_cycles),
    .uncondi_branch_num   (uncondi_branch_num),
    .condi_branch_num     (condi_branch_num),
    .ram_display_data_out (ram_display_data_out),
    .SEG                  (seg),
    .AN                   (an),
    .ovf                  (ovf)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete (got timeout, need finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full scan rotation: sync on digit 0, then compare AN and SEG per slot.
  task automatic check_frame(input string tag, input logic [63:0] glyphs);
    int budget;
    logic [7:0] e;
    logic [7:0] an_e;
    budget = 0;
    for (int d = 0; d < ND; d++) exp_q.push_back(glyphs[8*d +: 8]);
    @(negedge clk);
    while (an !== 8'hFE && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    if (an !== 8'hFE) begin
      check({tag, "_sync"}, {24'd0, an}, 32'hFE);
      exp_q.delete();
      return;
    end
    for (int d = 0; d < ND; d++) begin
      e    = exp_q.pop_front();
      an_e = ~(8'd1 << d);
      check($sformatf("%s_d%0d_an", tag, d), {24'd0, an}, {24'd0, an_e});
      check($sformatf("%s_d%0d_seg", tag, d), {24'd0, seg}, {24'd0, e});
      if (d < ND - 1) repeat (CD) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    display_op = 3'b000;
    led_cpu_enable = 1'b0;
    blank_en = 1'b0;
    led_data_in = '0;
    total_cycles = '0;
    uncondi_branch_num = '0;
    condi_branch_num = '0;
    ram_display_data_out = '0;

    // reset values
    wait_cycles(3);
    @(negedge clk);
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;

    // blank until the first tick, then the AN rotation
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pretick_an", {24'd0, an}, 32'hFF);
    check("pretick_seg", {24'd0, seg}, 32'hFF);
    @(posedge clk);
    @(negedge clk);
    check("scan0_an", {24'd0, an}, 32'hFE);
    check("scan0_seg", {24'd0, seg}, 32'hC0);
    for (int i = 1; i <= ND; i++) begin
      repeat (CD) @(posedge clk);
      @(negedge clk);
      check($sformatf("scan%0d_an", i), {24'd0, an}, {24'd0, ~(8'd1 << (i % ND))});
    end

    // CPU hex value loaded on a single enable pulse, then held
    wait_cycles(1);
    led_data_in = 32'h1234ABCD;
    led_cpu_enable = 1'b1;
    wait_cycles(1);
    led_cpu_enable = 1'b0;
    led_data_in = 32'hFFFFFFFF;
    wait_cycles(2);
    check_frame("cpu", 64'hF9A4B099_8883A7A1);
    check("cpu_ovf", {31'd0, ovf}, 32'd0);

    // decimal 305 with and without leading-zero blanking
    display_op = 3'b001;
    total_cycles = 32'd305;
    blank_en = 1'b1;
    wait_cycles(90);
    check_frame("tot_blank", 64'hFFFFFFFF_FFB0C092);
    check("tot_ovf", {31'd0, ovf}, 32'd0);
    blank_en = 1'b0;
    check_frame("tot_noblank", 64'hC0C0C0C0_C0B0C092);

    // overflow shows dashes; largest in-range value shows all nines
    display_op = 3'b111;
    condi_branch_num = 32'hFFFFFFFF;
    wait_cycles(90);
    check("cond_ovf_set", {31'd0, ovf}, 32'd1);
    check_frame("cond_dash", 64'hBFBFBFBF_BFBFBFBF);
    condi_branch_num = 32'd99_999_999;
    wait_cycles(90);
    check("cond_ovf_clr", {31'd0, ovf}, 32'd0);
    check_frame("cond_nines", 64'h98989898_98989898);

    // reset in the middle of a conversion aborts it
    display_op = 3'b011;
    uncondi_branch_num = 32'd7;
    blank_en = 1'b1;
    rst_n = 1'b0;
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(11);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_seg", {24'd0, seg}, 32'hFF);
    check("midrst_an", {24'd0, an}, 32'hFF);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    check_frame("unc_zero", 64'hFFFFFFFF_FFFFFFC0);
    check_frame("unc_seven", 64'hFFFFFFFF_FFFFFFF8);

    // undefined op blanks everything, then RAM hex
    wait_cycles(1);
    display_op = 3'b101;
    wait_cycles(10);
    check_frame("undef", 64'hFFFFFFFF_FFFFFFFF);
    check("undef_ovf", {31'd0, ovf}, 32'd0);
    display_op = 3'b010;
    ram_display_data_out = 32'h0000_00F0;
    wait_cycles(3);
    check_frame("ram", 64'hC0C0C0C0_C0C08EC0);
    check("ram_ovf", {31'd0, ovf}, 32'd0);

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
